// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared instruction types, IF/ID record and fetch FSM states
package mips_pkg;

  typedef logic [31:0] Instruct;

  localparam Instruct NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    Instruct     instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // A bubble carries no PC; pc_out reads zero whenever valid_out is low.
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with priority next-PC mux
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_branch,
  input  logic [31:0] branch_target,
  input  logic        sel_jump,
  input  logic [31:0] jump_target,
  input  logic        hold,
  output logic [31:0] pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] pc_next;

  // Branch beats jump beats hold; selects arrive already gated by the FSM.
  always_comb begin
    pc_next = pc + STEP;
    if (sel_branch) begin
      pc_next = branch_target;
    end else if (sel_jump) begin
      pc_next = jump_target;
    end else if (hold) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and halt FSM; FETCH_PERF_CNT_EN adds counters
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic        haltSignal,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output Instruct     instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        halted
);

  fetch_state_t state, state_next;
  ifid_t        ifid, ifid_next;
  logic [31:0]  pc;

  logic in_run;
  logic do_branch;
  logic do_jump;
  logic do_halt;
  logic do_stall;
  logic do_fetch;

  // One-hot decode of this cycle's action in priority order.
  always_comb begin
    in_run    = (state == FETCH_RUN);
    do_branch = in_run & branchTaken;
    do_jump   = in_run & ~branchTaken & jump;
    do_halt   = in_run & ~branchTaken & ~jump & haltSignal;
    do_stall  = in_run & ~branchTaken & ~jump & ~haltSignal & stall;
    do_fetch  = in_run & ~branchTaken & ~jump & ~haltSignal & ~stall;
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .sel_branch    (do_branch),
    .branch_target (branchTarget),
    .sel_jump      (do_jump),
    .jump_target   (jumpTarget),
    .hold          (~in_run | do_halt | do_stall),
    .pc            (pc)
  );

  always_comb begin
    state_next = state;
    ifid_next  = ifid;
    case (state)
      FETCH_RUN: begin
        if (do_branch || do_jump) begin
          ifid_next = IFID_BUBBLE;
        end else if (do_halt) begin
          state_next = FETCH_HALTED;
          ifid_next  = IFID_BUBBLE;
        end else if (do_fetch) begin
          ifid_next = '{instr: imem_rdata, pc: pc, valid: 1'b1};
        end
      end
      FETCH_HALTED: begin
        ifid_next = IFID_BUBBLE;
      end
      default: begin
        state_next = FETCH_RUN;
        ifid_next  = IFID_BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_RUN;
      ifid  <= IFID_BUBBLE;
    end else begin
      state <= state_next;
      ifid  <= ifid_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (do_fetch) begin
        fetch_cnt <= sat_inc32(fetch_cnt);
      end
      if (do_branch || do_jump || do_stall) begin
        bubble_cnt <= sat_inc32(bubble_cnt);
      end
    end
  end
`endif

  assign imem_addr = pc;
  assign instr_out = ifid.instr;
  assign pc_out    = ifid.pc;
  assign valid_out = ifid.valid;
  assign halted    = (state == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;

  logic        clk = 1'b0;
  logic        reset, stall, branchTaken, jump, haltSignal;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
  logic        valid_out, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .haltSignal   (haltSignal),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .halted       (halted)
  );

  // Reference: one clock of the fetch stage, written from the priority rules.
  task automatic model_step();
    if (reset) begin
      m_pc = RESET_PC; m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (branchTaken || jump) begin
      m_pc = branchTaken ? branchTarget : jumpTarget;
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (haltSignal) begin
      m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1;
      m_pc = m_pc + PC_STEP;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; jump = 1'b0; haltSignal = 1'b0;
    branchTarget = 32'h0; jumpTarget = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    total++; if (imem_addr !== RESET_PC) $display("FAIL reset_pc got %h exp %h", imem_addr, RESET_PC); else passed++;
    total++; if (instr_out !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr_out); else passed++;
    total++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out got %h exp 0", pc_out); else passed++;
    total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_out); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = RESET_PC + i * PC_STEP;
      total++; if (pc_out !== exp_pc) $display("FAIL seq_pc_out[%0d] got %h exp %h", i, pc_out, exp_pc); else passed++;
      total++; if (valid_out !== 1'b1) $display("FAIL seq_valid[%0d] got %b exp 1", i, valid_out); else passed++;
      total++; if (instr_out !== mem_word(exp_pc)) $display("FAIL seq_instr[%0d] got %h exp %h", i, instr_out, mem_word(exp_pc)); else passed++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    tick();
    total++; if (imem_addr !== 32'h8) $display("FAIL br_pre_pc got %h exp 8", imem_addr); else passed++;
    branchTaken = 1'b1; branchTarget = 32'h40;
    tick();
    branchTaken = 1'b0;
    total++; if (valid_out !== 1'b0) $display("FAIL br_bubble_valid got %b exp 0", valid_out); else passed++;
    total++; if (instr_out !== 32'h0) $display("FAIL br_bubble_instr got %h exp 0", instr_out); else passed++;
    total++; if (imem_addr !== 32'h40) $display("FAIL br_target_pc got %h exp 40", imem_addr); else passed++;
    tick();
    total++; if (valid_out !== 1'b1) $display("FAIL br_resume_valid got %b exp 1", valid_out); else passed++;
    total++; if (pc_out !== 32'h40) $display("FAIL br_resume_pc_out got %h exp 40", pc_out); else passed++;
    total++; if (instr_out !== mem_word(32'h40)) $display("FAIL br_resume_instr got %h exp %h", instr_out, mem_word(32'h40)); else passed++;
    // PC wraps modulo 2^32.
    jump = 1'b1; jumpTarget = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    tick();
    total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_out got %h exp fffffffc", pc_out); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_pc got %h exp 0", imem_addr); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_addr !== 32'h10) $display("FAIL stall_pc[%0d] got %h exp 10", i, imem_addr); else passed++;
      total++; if (instr_out !== mem_word(32'hC)) $display("FAIL stall_instr[%0d] got %h exp %h", i, instr_out, mem_word(32'hC)); else passed++;
      total++; if (pc_out !== 32'hC || valid_out !== 1'b1) $display("FAIL stall_ifid[%0d] got %h/%b exp c/1", i, pc_out, valid_out); else passed++;
    end
    stall = 1'b0;
    tick();
    total++; if (pc_out !== 32'h10 || valid_out !== 1'b1) $display("FAIL stall_resume got %h/%b exp 10/1", pc_out, valid_out); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    haltSignal = 1'b1;
    tick();
    haltSignal = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else passed++;
    total++; if (valid_out !== 1'b0) $display("FAIL halt_valid got %b exp 0", valid_out); else passed++;
    total++; if (imem_addr !== 32'h20) $display("FAIL halt_pc got %h exp 20", imem_addr); else passed++;
    jump = 1'b1; jumpTarget = 32'h80; branchTaken = 1'b1; branchTarget = 32'h90; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_addr !== 32'h20) $display("FAIL halt_frozen_pc[%0d] got %h exp 20", i, imem_addr); else passed++;
      total++; if (halted !== 1'b1 || valid_out !== 1'b0) $display("FAIL halt_hold[%0d] got %b/%b exp 1/0", i, halted, valid_out); else passed++;
    end
    idle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick();
    tick();
    haltSignal = 1'b1; branchTaken = 1'b1; branchTarget = 32'h100;
    tick();
    total++; if (halted !== 1'b0) $display("FAIL sim_halt_br_halted got %b exp 0", halted); else passed++;
    total++; if (imem_addr !== 32'h100) $display("FAIL sim_halt_br_pc got %h exp 100", imem_addr); else passed++;
    haltSignal = 1'b0; jump = 1'b1; branchTarget = 32'h200; jumpTarget = 32'h300;
    tick();
    total++; if (imem_addr !== 32'h200) $display("FAIL sim_br_jmp_pc got %h exp 200", imem_addr); else passed++;
    idle();
    haltSignal = 1'b1;
    tick();
    haltSignal = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL sim_pre_halted got %b exp 1", halted); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++; if (pc_out !== RESET_PC || valid_out !== 1'b1) $display("FAIL sim_reset_halted got %h/%b exp %h/1", pc_out, valid_out, RESET_PC); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL sim_reset_halted_flag got %b exp 0", halted); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      branchTaken  = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      haltSignal   = ($urandom_range(0, 39) == 0);
      branchTarget = $urandom() & 32'hFFFF_FFFC;
      jumpTarget   = $urandom() & 32'hFFFF_FFFC;
      tick();
      total++; if (imem_addr !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", i, imem_addr, m_pc); else passed++;
      total++; if (valid_out !== m_valid || halted !== m_halted) $display("FAIL rnd_flags[%0d] got %b%b exp %b%b", i, valid_out, halted, m_valid, m_halted); else passed++;
      total++; if (instr_out !== m_instr) $display("FAIL rnd_instr[%0d] got %h exp %h", i, instr_out, m_instr); else passed++;
      if (m_valid) begin
        total++; if (pc_out !== m_pcout) $display("FAIL rnd_pc_out[%0d] got %h exp %h", i, pc_out, m_pcout); else passed++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first byte address fetched after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, meaning hold the PC and the IF/ID register (load-use or other hazard).
REQ-006 SHALL have port branchTaken, input, 1, meaning redirect the PC to branchTarget.
REQ-007 SHALL have port branchTarget, input, 32, meaning the branch destination byte address.
REQ-008 SHALL have port jump, input, 1, meaning redirect the PC to jumpTarget.
REQ-009 SHALL have port jumpTarget, input, 32, meaning the JR destination byte address.
REQ-010 SHALL have port haltSignal, input, 1, meaning the decoder has seen HALT in ID.
REQ-011 SHALL have port imem_addr, output, 32, meaning the instruction memory byte address, equal to the current PC.
REQ-012 SHALL have port imem_rdata, input, 32, meaning the combinational instruction word at imem_addr.
REQ-013 SHALL have port instr_out, output, Instruct (32), meaning the IF/ID instruction that feeds the decoder.
REQ-014 SHALL have port pc_out, output, 32, meaning the PC of instr_out.
REQ-015 SHALL have port valid_out, output, 1, meaning instr_out is a real instruction and not a bubble.
REQ-016 SHALL have port halted, output, 1, meaning fetch has stopped permanently.

Function
REQ-017 SHALL apply next-state priority per cycle: reset > branchTaken > jump > halt > stall > sequential.
REQ-018 SHALL, on sequential advance, set PC <= PC+PC_STEP (mod 2^32) and IF/ID <= {imem_rdata, PC, valid=1}, giving 1-cycle latency from PC to instr_out.
REQ-019 SHALL, on branchTaken, set PC <= branchTarget and load IF/ID with NOP (32'h0) and valid=0 for exactly one cycle, even if stall is high.
REQ-020 SHALL, on jump with branchTaken low, behave as REQ-019 using jumpTarget.
REQ-021 SHALL, on stall with no redirect, hold PC, instr_out, pc_out and valid_out unchanged.
REQ-022 SHALL implement the FSM RUN -> HALTED when haltSignal=1 in RUN and no redirect is asserted in the same cycle.
REQ-023 SHALL, when haltSignal and a redirect coincide, take the redirect, stay in RUN, and ignore the halt.
REQ-024 SHALL, in HALTED, freeze PC, hold IF/ID at NOP with valid=0, assert halted=1, and ignore stall, branchTaken and jump.
REQ-025 SHALL leave HALTED only through reset.
REQ-026 SHALL keep imem_addr combinationally equal to the PC register, with no gating.

Reset
REQ-027 SHALL, on reset, set PC=RESET_PC, instr_out=32'h0, pc_out=32'h0, valid_out=0, halted=0, FSM=RUN, and clear all counters.
REQ-028 SHALL let reset asserted mid-redirect, mid-stall or in HALTED override everything, with the first valid fetch of RESET_PC appearing on instr_out one cycle after reset deasserts.

Configuration
REQ-029 SHALL, when FETCH_PERF_CNT_EN is defined, add 32-bit saturating outputs fetch_cnt (increments per valid IF/ID load) and bubble_cnt (increments per redirect or stall cycle in RUN).
REQ-030 SHALL, when FETCH_PERF_CNT_EN is undefined, contain neither the counter ports nor the counter logic.

Structure
REQ-031 SHALL place the Instruct typedef, the NOP_INSTR constant (32'h0) and the fetch FSM state enum in mips_pkg.
REQ-032 SHALL use one sub-module, fetch_pc_reg, containing the PC register and next-PC mux; the IF/ID register and FSM live in fetch_stage.

Verification
REQ-033 SHALL cover sequential fetch: reset, then 4 cycles free-running -> pc_out 0,4,8,C on consecutive cycles with valid_out=1.
REQ-034 SHALL cover branch redirect: branchTaken=1 with branchTarget=32'h40 at PC=8 -> next cycle valid_out=0, then instr at 0x40 with pc_out=0x40.
REQ-035 SHALL cover stall: stall=1 for 3 cycles at PC=0x10 -> imem_addr=0x10 and instr_out held for 3 cycles, then resumes with 0x10.
REQ-036 SHALL cover halt: haltSignal=1 at PC=0x20 -> halted=1 next cycle, valid_out=0, PC frozen at 0x20 despite jump=1.
REQ-037 SHALL cover simultaneous events: haltSignal=1 with branchTaken=1 -> redirect taken and halted stays 0; branchTaken=1 with jump=1 -> PC=branchTarget; reset while HALTED -> pc_out=RESET_PC with valid_out=1 one cycle after reset deasserts.
